// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - address map and CTRL bit positions for the MMIO responder
package mmio_pkg;

  localparam logic [31:0] UART_CTRL = 32'h8000_0000;
  localparam logic [31:0] UART_RX   = 32'h8000_0004;
  localparam logic [31:0] UART_TX   = 32'h8000_0008;
  localparam logic [31:0] UART_CC   = 32'h8000_0010;
  localparam logic [31:0] UART_IC   = 32'h8000_0014;
  localparam logic [31:0] UART_RST  = 32'h8000_0018;

  localparam int CTRL_TX_NOTFULL  = 0;
  localparam int CTRL_RX_NONEMPTY = 1;
  localparam int CTRL_TX_OVF      = 2;

endpackage

// File: rtl/io_fifo.sv
// rtl/io_fifo.sv - synchronous FIFO with extra-MSB pointers; push is ignored when full, pop when empty
module io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  // Empty reads as zero so stale storage never leaks to the bus or the UART.
  assign dout  = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wptr[AW-1:0]] <= din;
        wptr              <= wptr + 1'b1;
      end
      if (pop && !empty) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_io.sv
// rtl/mmio_io.sv - MMIO responder: UART RX/TX FIFOs, cycle/instret counters, load data returned at mem/wb
module mmio_io
  import mmio_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              io_rd_en,
  input  logic              io_wr_en,
  input  logic              data_out_ready,
  input  logic              data_in_valid,
  input  logic              inst_retire,
  output logic [31:0]       rdata,
  output logic [DATA_W-1:0] uart_tx_data,
  output logic              uart_tx_valid,
  input  logic              uart_tx_ready,
  input  logic [DATA_W-1:0] uart_rx_data,
  input  logic              uart_rx_valid,
  output logic              uart_rx_ready
);

  logic              rx_full, rx_empty, tx_full, tx_empty;
  logic [DATA_W-1:0] rx_head, tx_head;
  logic              tx_ovf;
  logic [31:0]       cc, ic;
  logic [31:0]       rd_val, rd_stage;
  logic              rd_pend;
  logic              clr;
  logic              unused_wdata;

  assign unused_wdata = ^wdata[31:DATA_W];

  assign uart_rx_ready = !rx_full;
  assign uart_tx_valid = !tx_empty;
  assign uart_tx_data  = tx_head;
  assign clr           = io_wr_en && (addr == UART_RST);

  io_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (uart_rx_valid),
    .pop   (data_out_ready),
    .din   (uart_rx_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  io_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (data_in_valid),
    .pop   (uart_tx_ready),
    .din   (wdata[DATA_W-1:0]),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // Status and counters are sampled before this edge's updates.
  always_comb begin
    rd_val = '0;
    case (addr)
      UART_CTRL: begin
        rd_val[CTRL_TX_NOTFULL]  = !tx_full;
        rd_val[CTRL_RX_NONEMPTY] = !rx_empty;
        rd_val[CTRL_TX_OVF]      = tx_ovf;
      end
      UART_RX: rd_val = 32'(rx_head);
      UART_CC: rd_val = cc;
      UART_IC: rd_val = ic;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cc       <= '0;
      ic       <= '0;
      tx_ovf   <= 1'b0;
      rd_pend  <= 1'b0;
      rd_stage <= '0;
      rdata    <= '0;
    end else begin
      cc <= clr ? '0 : cc + 32'd1;
      if (clr) begin
        ic <= '0;
      end else if (inst_retire) begin
        ic <= ic + 32'd1;
      end
      if (clr) begin
        tx_ovf <= 1'b0;
      end else if (data_in_valid && tx_full) begin
        tx_ovf <= 1'b1;
      end
      // Two-stage load path so rdata lands with the core's mem/wb stage.
      rd_pend <= io_rd_en;
      if (io_rd_en) begin
        rd_stage <= rd_val;
      end
      if (rd_pend) begin
        rdata <= rd_stage;
      end
    end
  end

endmodule

// File: tb/tb_mmio_io.sv
// tb/tb_mmio_io.sv - scoreboard bench for mmio_io with directed vectors
module tb_mmio_io;
  import mmio_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        io_rd_en = 1'b0;
  logic        io_wr_en = 1'b0;
  logic        data_out_ready = 1'b0;
  logic        data_in_valid = 1'b0;
  logic        inst_retire = 1'b0;
  logic [31:0] rdata;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready = 1'b0;
  logic [7:0]  uart_rx_data = '0;
  logic        uart_rx_valid = 1'b0;
  logic        uart_rx_ready;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  tx_q[$];
  logic        p1 = 1'b0;
  logic        p2 = 1'b0;

  always #5 clk = ~clk;

  mmio_io #(.FIFO_DEPTH(4), .DATA_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .addr           (addr),
    .wdata          (wdata),
    .io_rd_en       (io_rd_en),
    .io_wr_en       (io_wr_en),
    .data_out_ready (data_out_ready),
    .data_in_valid  (data_in_valid),
    .inst_retire    (inst_retire),
    .rdata          (rdata),
    .uart_tx_data   (uart_tx_data),
    .uart_tx_valid  (uart_tx_valid),
    .uart_tx_ready  (uart_tx_ready),
    .uart_rx_data   (uart_rx_data),
    .uart_rx_valid  (uart_rx_valid),
    .uart_rx_ready  (uart_rx_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Load data is due two edges after the request was presented.
  always @(negedge clk) begin
    if (p2) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rdata_extra: got %0h expected no load", rdata);
      end else begin
        chk("rdata", rdata, exp_q.pop_front());
      end
    end
    p2 = p1;
    p1 = io_rd_en;
    if (uart_tx_valid && uart_tx_ready) begin
      if (tx_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tx_extra: got %0h expected no byte", uart_tx_data);
      end else begin
        chk("uart_tx_data", 32'(uart_tx_data), 32'(tx_q.pop_front()));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    addr = a;
    io_rd_en = 1'b1;
    data_out_ready = (a == UART_RX);
    exp_q.push_back(e);
    cyc();
    io_rd_en = 1'b0;
    data_out_ready = 1'b0;
    addr = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic accepted);
    addr = a;
    wdata = d;
    io_wr_en = 1'b1;
    data_in_valid = (a == UART_TX);
    if (accepted) tx_q.push_back(d[7:0]);
    cyc();
    io_wr_en = 1'b0;
    data_in_valid = 1'b0;
    addr = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", rdata, 0);
    chk("rst_rx_ready", 32'(uart_rx_ready), 1);
    chk("rst_tx_valid", 32'(uart_tx_valid), 0);
    chk("rst_tx_data", 32'(uart_tx_data), 0);
    rst = 1'b0;
    cyc();
    rd(UART_CC, 32'd1);

    // RX loopback
    uart_rx_valid = 1'b1;
    uart_rx_data = 8'h41;
    cyc();
    uart_rx_data = 8'h42;
    cyc();
    uart_rx_valid = 1'b0;
    rd(UART_CTRL, 32'h3);
    rd(UART_RX, 32'h41);
    rd(UART_RX, 32'h42);
    rd(UART_RX, 32'h0);
    rd(UART_CTRL, 32'h1);

    // RX full: the fifth byte waits one cycle after the pop
    uart_rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      uart_rx_data = 8'(8'h10 + i);
      cyc();
    end
    uart_rx_valid = 1'b0;
    chk("rx_ready_full", 32'(uart_rx_ready), 0);
    uart_rx_valid = 1'b1;
    uart_rx_data = 8'h14;
    rd(UART_RX, 32'h10);
    chk("rx_ready_after_pop", 32'(uart_rx_ready), 1);
    cyc();
    uart_rx_valid = 1'b0;
    chk("rx_ready_refull", 32'(uart_rx_ready), 0);
    rd(UART_RX, 32'h11);
    rd(UART_RX, 32'h12);
    rd(UART_RX, 32'h13);
    rd(UART_RX, 32'h14);
    rd(UART_CTRL, 32'h1);

    // TX push, overflow, drain
    wr(UART_TX, 32'h155, 1'b1);
    chk("tx_valid", 32'(uart_tx_valid), 1);
    chk("tx_data_first", 32'(uart_tx_data), 32'h55);
    wr(UART_TX, 32'h66, 1'b1);
    wr(UART_TX, 32'h77, 1'b1);
    wr(UART_TX, 32'h88, 1'b1);
    rd(UART_CTRL, 32'h0);
    wr(UART_TX, 32'h99, 1'b0);
    rd(UART_CTRL, 32'h4);
    uart_tx_ready = 1'b1;
    repeat (4) cyc();
    uart_tx_ready = 1'b0;
    chk("tx_valid_drained", 32'(uart_tx_valid), 0);
    chk("rdata_hold", rdata, 32'h4);
    wr(UART_RST, 32'h0, 1'b0);
    rd(UART_CTRL, 32'h1);
    for (int i = 0; i < 4; i++) wr(UART_TX, 32'(8'hA0 + i), 1'b1);
    uart_tx_ready = 1'b1;
    wr(UART_TX, 32'hA4, 1'b0);
    repeat (3) cyc();
    uart_tx_ready = 1'b0;
    rd(UART_CTRL, 32'h5);

    // Counters
    wr(UART_RST, 32'h0, 1'b0);
    inst_retire = 1'b1;
    repeat (10) cyc();
    inst_retire = 1'b0;
    rd(UART_IC, 32'd10);
    inst_retire = 1'b1;
    wr(UART_RST, 32'h1234, 1'b0);
    inst_retire = 1'b0;
    rd(UART_IC, 32'd0);
    rd(UART_CC, 32'd1);
    force dut.cc = 32'hFFFF_FFFF;
    #1;
    release dut.cc;
    rd(UART_CC, 32'hFFFF_FFFF);
    rd(UART_CC, 32'h0);

    // Unmapped and write-only accesses
    inst_retire = 1'b1;
    repeat (3) cyc();
    inst_retire = 1'b0;
    rd(UART_IC, 32'd3);
    uart_rx_valid = 1'b1;
    uart_rx_data = 8'h5A;
    cyc();
    uart_rx_valid = 1'b0;
    rd(32'h8000_000C, 32'h0);
    wr(UART_CTRL, 32'hFF, 1'b0);
    rd(UART_TX, 32'h0);
    rd(UART_RST, 32'h0);
    rd(UART_IC, 32'd3);
    rd(UART_CTRL, 32'h3);
    rd(UART_RX, 32'h5A);
    rd(UART_CTRL, 32'h1);

    // Reset mid-operation drops buffered bytes and the reset-cycle handshake
    repeat (3) cyc();
    uart_rx_valid = 1'b1;
    uart_rx_data = 8'h77;
    cyc();
    rst = 1'b1;
    uart_rx_data = 8'h78;
    cyc();
    rst = 1'b0;
    uart_rx_valid = 1'b0;
    chk("midrst_rdata", rdata, 0);
    chk("midrst_rx_ready", 32'(uart_rx_ready), 1);
    rd(UART_CTRL, 32'h1);
    rd(UART_RX, 32'h0);

    repeat (3) cyc();
    chk("rdata_queue_empty", 32'(exp_q.size()), 0);
    chk("tx_queue_empty", 32'(tx_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_io.md
# mmio_io

Memory-mapped I/O responder for the RISC-V core. It decodes load/store requests issued by the core's execute stage to the `0x8000_00xx` window and buffers bytes between the core and the UART in RX and TX FIFOs. It also maintains the cycle and retired-instruction counters and returns load data one cycle later, aligned with the core's mem/wb stage.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4. Entries per RX/TX FIFO; power of two, ≥2.
- `DATA_W`, default 8. UART byte width.

Ports:
- `clk` in 1. Single clock for the whole block.
- `rst` in 1. Synchronous, active-high reset.
- `addr` in 32. Execute-stage ALU result (byte address).
- `wdata` in 32. Store data; only `[7:0]` is used for TX.
- `io_rd_en` in 1. Execute stage holds a load to the MMIO window.
- `io_wr_en` in 1. Execute stage holds a store to the MMIO window.
- `data_out_ready` in 1. Load from `UART_RX`; pops the RX FIFO.
- `data_in_valid` in 1. Store to `UART_TX`; pushes the TX FIFO.
- `inst_retire` in 1. A real instruction (not an injected NOP) left mem/wb this cycle.
- `rdata` out 32. Registered load data.
- `uart_tx_data` out `DATA_W`. Byte offered to the UART transmitter.
- `uart_tx_valid` out 1. TX FIFO is not empty.
- `uart_tx_ready` in 1. Transmitter accepts the offered byte.
- `uart_rx_data` in `DATA_W`. Byte from the UART receiver.
- `uart_rx_valid` in 1. Receiver has a byte.
- `uart_rx_ready` out 1. RX FIFO is not full.

## Operation
Address map (exact 32-bit compare):
- `0x80000000` CTRL (read): `{29'b0, tx_ovf, rx_nonempty, tx_notfull}`.
- `0x80000004` RX (read): `{24'b0, rx_head}`; pops the FIFO.
- `0x80000008` TX (write): pushes `wdata[7:0]`.
- `0x80000010` CC (read): cycle counter.
- `0x80000014` IC (read): instruction counter.
- `0x80000018` RST (write, any data): clears CC, IC and `tx_ovf`.

Access rules:
- A read of any other address with `io_rd_en`, or of a write-only register, returns 0.
- Writes to read-only or unmapped addresses are ignored.

Counters:
- CC increments every cycle out of reset.
- IC increments when `inst_retire=1`.
- Both are 32-bit and wrap from `0xFFFFFFFF` to 0.
- When a store to RST and an increment occur in the same cycle, the reset wins: the counter becomes 0.
- CC/IC reads return the pre-update value of that cycle.

RX FIFO:
- Push when `uart_rx_valid && uart_rx_ready`, with `uart_rx_ready = !rx_full`.
- Pop when `data_out_ready && rx_nonempty`.
- When full, `uart_rx_ready=0` even if a pop happens in the same cycle; the byte is accepted next cycle.
- Popping an empty FIFO is a no-op and `rdata` returns `{24'b0, 8'h00}`.
- When empty, a push and a pop in the same cycle perform the push only.

TX FIFO:
- Push on `data_in_valid` when not full.
- `uart_tx_valid = !tx_empty`; pop when `uart_tx_valid && uart_tx_ready`.
- A push to a full FIFO drops the byte and sets sticky `tx_ovf`.
- A push and a pop in the same cycle on a full FIFO: pop only, the push is dropped and `tx_ovf` is set. Software must poll CTRL bit 0.

Each FIFO uses read/write pointers one bit wider than `log2(FIFO_DEPTH)`:
- Full when the MSBs differ and the remaining bits are equal.
- Empty when the pointers are equal.
- Pointers wrap naturally.

## Timing
- Request sampled at edge N (execute stage). `rdata` is valid after edge N+1 and holds until the next `io_rd_en`.
- RX pop, TX push, counter clear and `tx_ovf` updates all take effect at edge N.
- CTRL status reflects FIFO state before that edge.
- `uart_tx_data` and `uart_tx_valid` are combinational from TX FIFO state: a byte pushed at edge N is offered from cycle N+1.
- Reset values:
  - `rdata=0`, `uart_tx_valid=0`, `uart_tx_data=0`, `uart_rx_ready=1`.
  - CC=0, IC=0, `tx_ovf=0`, all pointers 0.
- Reset mid-operation discards all FIFO contents. A UART handshake in the reset cycle is not recorded.

## Structure
- Shared package `mmio_pkg` holds:
  - address constants `UART_CTRL`, `UART_RX`, `UART_TX`, `UART_CC`, `UART_IC`, `UART_RST`;
  - CTRL bit indices `CTRL_TX_NOTFULL=0`, `CTRL_RX_NONEMPTY=1`, `CTRL_TX_OVF=2`.
- One sub-module, `io_fifo`: synchronous FIFO parameterized by `WIDTH`/`DEPTH`, with ports `push`, `pop`, `din`, `dout`, `full`, `empty`. It is instantiated twice.
- Address decode, counters and the `rdata` register live in the top level.

## Test plan
- **Reset:** hold `rst` 2 cycles. Expect `rdata=0`, `uart_rx_ready=1`, `uart_tx_valid=0`. A CC read at cycle 1 after release returns 1.
- **RX loopback:** drive bytes `0x41`, `0x42`. Expect CTRL read = `0x3`. Two RX reads return `0x41` then `0x42`, each one cycle after its request. A third read returns 0 and CTRL = `0x1`.
- **RX full:** push 4 bytes, then `uart_rx_ready=0`. Pop and push in the same cycle: the push stalls one cycle and all 5 bytes are delivered in order.
- **TX:** store `0x155` to TX with `uart_tx_ready=0`. Expect `uart_tx_data=0x55` and `uart_tx_valid=1` next cycle. A 5th push sets CTRL bit 2. Raising `uart_tx_ready` drains 4 bytes.
- **Counters:** pulse `inst_retire` 10 times; IC reads 10. Store to RST in the same cycle as `inst_retire`; IC and CC read 0/1 afterward. Force CC to `0xFFFFFFFF`; it wraps to 0.
- **Unmapped:** read `0x8000000C`; expect `rdata=0`, and neither FIFO nor any counter changes.
